// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO; frame format set by parameters,
// bit timing driven by an external one-cycle baud tick (clk_en).
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          start,
    input  logic [DATA_BITS-1:0]          data,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 w_full, w_empty, w_push, w_pop;
    logic [DATA_BITS-1:0] w_rd_word;

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par;
    logic                 r_tx;
    logic                 w_tx_nxt, w_shift_en, w_bit_clr, w_bit_inc, w_stop_clr, w_stop_inc;

    // full is taken from the registered level, so a same-cycle pop never frees a slot
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = start && !w_full;
    assign w_rd_word = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; pointers and level alone define its contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: each combinational block assigns defaults first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (clk_en) begin
            unique case (r_state)
                S_IDLE:   if (!w_empty) w_state_nxt = S_START;
                S_START:  w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == LAST_BIT)
                              w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   if (r_stop_cnt == LAST_STOP)
                              w_state_nxt = w_empty ? S_IDLE : S_START;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pop      = 1'b0;
        w_tx_nxt   = r_tx;
        w_shift_en = 1'b0;
        w_bit_clr  = 1'b0;
        w_bit_inc  = 1'b0;
        w_stop_clr = 1'b0;
        w_stop_inc = 1'b0;
        if (clk_en) begin
            unique case (r_state)
                S_IDLE: if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_tx_nxt = 1'b0;
                end
                S_START: begin
                    w_tx_nxt  = r_shift[0];
                    w_bit_clr = 1'b1;
                end
                S_DATA: if (r_bit_cnt == LAST_BIT) begin
                    w_tx_nxt   = (PARITY != 0) ? r_par : 1'b1;
                    w_stop_clr = 1'b1;
                end else begin
                    w_tx_nxt   = r_shift[1];
                    w_shift_en = 1'b1;
                    w_bit_inc  = 1'b1;
                end
                S_PARITY: begin
                    w_tx_nxt   = 1'b1;
                    w_stop_clr = 1'b1;
                end
                S_STOP: if (r_stop_cnt == LAST_STOP) begin
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_tx_nxt = 1'b0;
                    end
                end else begin
                    w_stop_inc = 1'b1;
                end
                default: w_tx_nxt = 1'b1;
            endcase
        end
    end

    // tx resets asynchronously, so a truncated frame releases the line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_tx <= w_tx_nxt;
            if (w_pop) begin
                r_shift <= w_rd_word;
                r_par   <= (PARITY == 2) ? ^w_rd_word : ~^w_rd_word;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_clr)      r_bit_cnt <= '0;
            else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_stop_clr)      r_stop_cnt <= 1'b0;
            else if (w_stop_inc) r_stop_cnt <= r_stop_cnt + 1'b1;
        end
    end

    assign full     = w_full;
    assign overflow = start && w_full;
    assign level    = r_level;
    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE) || !w_empty;

endmodule
